// File: rtl/and_gate_unit.sv
// and_gate_unit: bitwise AND leaf primitive with registered observers.
//   y and all_one are purely combinational (zero latency); y_q, rise and
//   ones_cnt update on the rising edge of clk, one cycle after the inputs.
//   There is no handshake: every output is defined every cycle.
//
// Ports:
//   clk       in   1      rising-edge clock, used only by registered outputs
//   rst       in   1      asynchronous active-high reset for registered state
//   a, b      in   WIDTH  operands
//   y         out  WIDTH  a & b, combinational
//   y_q       out  WIDTH  y delayed by one clock
//   all_one   out  1      combinational, y is all ones
//   rise      out  1      one-cycle pulse when all_one goes 0 -> 1
//   ones_cnt  out  CNT_W  saturating count of cycles sampled with all_one=1

module and_gate_unit #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             all_one,
  output logic             rise,
  output logic [CNT_W-1:0] ones_cnt
);

  // Previous-cycle all_one, used to detect the 0 -> 1 transition.
  logic all_one_d;

  // Continuous assigns keep y independent of clk/rst and propagate X/Z
  // with ordinary & semantics (0 & X = 0).
  assign y       = a & b;
  assign all_one = &y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q       <= '0;
      all_one_d <= 1'b0;
      rise      <= 1'b0;
    end else begin
      y_q       <= y;
      all_one_d <= all_one;
      // all_one_d is cleared by reset, so an all-ones first cycle after
      // reset release produces a pulse.
      rise      <= all_one & ~all_one_d;
    end
  end

  // Counter saturates at all ones; it never wraps back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_cnt <= '0;
    end else if (all_one && (ones_cnt != {CNT_W{1'b1}})) begin
      ones_cnt <= ones_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_and_gate_unit.sv
module tb_and_gate_unit;

  typedef struct {
    int          sel;
    logic [15:0] exp;
    string       name;
  } chk_t;

  localparam int S_Y1    = 0;
  localparam int S_ALL1  = 1;
  localparam int S_Y8    = 2;
  localparam int S_ALL8  = 3;
  localparam int S_YQ8   = 4;
  localparam int S_RISE8 = 5;
  localparam int S_CNT8  = 6;
  localparam int S_CNT2  = 7;
  localparam int S_RISE2 = 8;

  chk_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  logic rst;
  logic rst2;

  // WIDTH=1 instance whose clock and reset are never driven.
  logic       clk_nc;
  logic       rst_nc;
  logic [0:0] a1, b1, y1, yq1;
  logic       all1, rise1;
  logic [15:0] cnt1;

  logic [7:0]  a8, b8, y8, yq8;
  logic        all8, rise8;
  logic [15:0] cnt8;

  logic [0:0] a2, b2, y2, yq2;
  logic       all2, rise2;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  and_gate_unit #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk(clk_nc), .rst(rst_nc), .a(a1), .b(b1), .y(y1), .y_q(yq1),
    .all_one(all1), .rise(rise1), .ones_cnt(cnt1)
  );

  and_gate_unit #(.WIDTH(8), .CNT_W(16)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .y(y8), .y_q(yq8),
    .all_one(all8), .rise(rise8), .ones_cnt(cnt8)
  );

  and_gate_unit #(.WIDTH(1), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst2), .a(a2), .b(b2), .y(y2), .y_q(yq2),
    .all_one(all2), .rise(rise2), .ones_cnt(cnt2)
  );

  function automatic logic [15:0] actual(int sel);
    logic [15:0] v;
    v = 16'h0000;
    case (sel)
      S_Y1:    v = {15'h0, y1};
      S_ALL1:  v = {15'h0, all1};
      S_Y8:    v = {8'h00, y8};
      S_ALL8:  v = {15'h0, all8};
      S_YQ8:   v = {8'h00, yq8};
      S_RISE8: v = {15'h0, rise8};
      S_CNT8:  v = cnt8;
      S_CNT2:  v = {14'h0, cnt2};
      S_RISE2: v = {15'h0, rise2};
      default: v = 16'hdead;
    endcase
    return v;
  endfunction

  task automatic expect_val(input int sel, input logic [15:0] exp, input string name);
    chk_t c;
    c.sel  = sel;
    c.exp  = exp;
    c.name = name;
    q.push_back(c);
  endtask

  // Stimulus pushes only after inputs have settled and then waits before
  // touching inputs again, so the monitor samples a stable DUT.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expectation whenever one is present and compares it
  // against the DUT output it names.
  initial begin
    chk_t        c;
    logic [15:0] act;
    forever begin
      wait (q.size() != 0);
      c   = q.pop_front();
      act = actual(c.sel);
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s got %h want %h at %0t", c.name, act, c.exp, $time);
      end
    end
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    a8 = 8'h00; b8 = 8'h00; a2 = 1'b0; b2 = 1'b0;
    a1 = 1'b0;  b1 = 1'b0;

    // Unclocked WIDTH=1 truth table, plus X handling.
    a1 = 1'b0; b1 = 1'b0; #2; expect_val(S_Y1, 16'h0, "w1_00"); #8;
    a1 = 1'b0; b1 = 1'b1; #2; expect_val(S_Y1, 16'h0, "w1_01"); #8;
    a1 = 1'b1; b1 = 1'b0; #2; expect_val(S_Y1, 16'h0, "w1_10"); #8;
    a1 = 1'b1; b1 = 1'b1; #2; expect_val(S_Y1, 16'h1, "w1_11");
    expect_val(S_ALL1, 16'h1, "w1_all_one"); #8;
    a1 = 1'b0; b1 = 1'bx; #2; expect_val(S_Y1, 16'h0, "w1_0x"); #8;
    a1 = 1'b1; b1 = 1'bx; #2; expect_val(S_Y1, {15'h0, 1'bx}, "w1_1x"); #8;

    // WIDTH=8 combinational patterns, checked while still in reset.
    a8 = 8'hF0; b8 = 8'h3C; #2;
    expect_val(S_Y8, 16'h0030, "w8_f0_3c"); expect_val(S_ALL8, 16'h0, "w8_all_f0_3c"); #8;
    a8 = 8'hFF; b8 = 8'hFF; #2;
    expect_val(S_Y8, 16'h00FF, "w8_ff_ff"); expect_val(S_ALL8, 16'h1, "w8_all_ff"); #8;
    a8 = 8'hA5; b8 = 8'h5A; #2;
    expect_val(S_Y8, 16'h0000, "w8_a5_5a"); expect_val(S_ALL8, 16'h0, "w8_all_a5"); #8;

    // Reset state after clock edges with rst held high.
    tick();
    expect_val(S_YQ8, 16'h0, "rst_yq"); expect_val(S_RISE8, 16'h0, "rst_rise");
    expect_val(S_CNT8, 16'h0, "rst_cnt"); expect_val(S_CNT2, 16'h0, "rst_cnt2");
    #1;

    // Release reset away from an edge, then three all-ones cycles.
    rst = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    tick();
    expect_val(S_YQ8, 16'h00FF, "t3_yq1"); expect_val(S_RISE8, 16'h1, "t3_rise1");
    expect_val(S_CNT8, 16'd1, "t3_cnt1"); #1;
    tick();
    expect_val(S_RISE8, 16'h0, "t3_rise2"); expect_val(S_CNT8, 16'd2, "t3_cnt2"); #1;
    tick();
    expect_val(S_RISE8, 16'h0, "t3_rise3"); expect_val(S_CNT8, 16'd3, "t3_cnt3"); #1;
    a8 = 8'h00; #1;
    expect_val(S_Y8, 16'h0000, "t3_y_drop"); expect_val(S_YQ8, 16'h00FF, "t3_yq_late");
    tick();
    expect_val(S_YQ8, 16'h0000, "t3_yq4"); expect_val(S_RISE8, 16'h0, "t3_rise4");
    expect_val(S_CNT8, 16'd3, "t3_cnt4"); #1;
    tick();
    expect_val(S_CNT8, 16'd3, "t3_cnt_hold"); #1;

    // Async reset between edges mid-count.
    a8 = 8'hFF;
    tick();
    expect_val(S_CNT8, 16'd4, "t5_cnt_pre"); expect_val(S_RISE8, 16'h1, "t5_rise_pre");
    #2;
    rst = 1'b1; #1;
    expect_val(S_YQ8, 16'h0, "t5_yq_async"); expect_val(S_RISE8, 16'h0, "t5_rise_async");
    expect_val(S_CNT8, 16'h0, "t5_cnt_async"); expect_val(S_Y8, 16'h00FF, "t5_y_live");
    expect_val(S_ALL8, 16'h1, "t5_all_live");
    tick();
    expect_val(S_CNT8, 16'h0, "t5_cnt_held"); #1;
    rst = 1'b0; a8 = 8'h00;

    // Toggle a: 1,0,1 with b all ones -> two rise pulses, count 2.
    tick();
    expect_val(S_RISE8, 16'h0, "t6_r0"); expect_val(S_CNT8, 16'd0, "t6_c0"); #1;
    a8 = 8'hFF;
    tick();
    expect_val(S_RISE8, 16'h1, "t6_r1"); expect_val(S_CNT8, 16'd1, "t6_c1"); #1;
    a8 = 8'h00;
    tick();
    expect_val(S_RISE8, 16'h0, "t6_r2"); expect_val(S_CNT8, 16'd1, "t6_c2"); #1;
    a8 = 8'hFF;
    tick();
    expect_val(S_RISE8, 16'h1, "t6_r3"); expect_val(S_CNT8, 16'd2, "t6_c3"); #1;
    a8 = 8'h00;
    tick();
    expect_val(S_RISE8, 16'h0, "t6_r4"); expect_val(S_CNT8, 16'd2, "t6_c4"); #1;

    // CNT_W=2 saturation: 1,2,3,3,3,3.
    rst2 = 1'b0; a2 = 1'b1; b2 = 1'b1;
    tick(); expect_val(S_CNT2, 16'd1, "t4_c1"); expect_val(S_RISE2, 16'h1, "t4_r1"); #1;
    tick(); expect_val(S_CNT2, 16'd2, "t4_c2"); expect_val(S_RISE2, 16'h0, "t4_r2"); #1;
    tick(); expect_val(S_CNT2, 16'd3, "t4_c3"); #1;
    tick(); expect_val(S_CNT2, 16'd3, "t4_c4"); #1;
    tick(); expect_val(S_CNT2, 16'd3, "t4_c5"); #1;
    tick(); expect_val(S_CNT2, 16'd3, "t4_c6"); #1;
    #2;
    rst2 = 1'b1; #1;
    expect_val(S_CNT2, 16'd0, "t4_cnt_async_rst");
    #5;

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 100 && q.size() != 0; i++) #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
